// File: rtl/cpu_wb_arbiter.sv
// Writeback arbiter: merges the in-order pipeline writeback with buffered long-latency results.
// Optional starvation guard (wait counter, pipe_stall, err) under WB_ARB_STARVE_GUARD_EN.
module cpu_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [REG_W-1:0]  pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              lu_valid,
    input  logic [REG_W-1:0]  lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_rd,
    output logic [DATA_W-1:0] rf_data,
    output logic              pipe_stall,
    output logic              err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    wb_t           mem [DEPTH];
    wb_t           head;
    logic [AW:0]   occ;
    logic [AW-1:0] rptr, wptr;
    logic          empty, grant, bypass, enq, stall_q;

    assign head     = mem[rptr];
    assign empty    = (occ == '0);
    assign lu_ready = !reset && (occ < OCC_FULL);

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(STARVE_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(STARVE_MAX - 1);

    logic [WW-1:0] wait_cnt;
    logic          err_q;

    // A stall cycle hands the slot to the head regardless of the pipe.
    assign grant = stall_q ? !empty : (!pipe_we && !empty);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            stall_q <= 1'b0;
            if (!empty && !grant) begin
                if (wait_cnt == WAIT_LAST) begin
                    wait_cnt <= '0;
                    stall_q  <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
            if (stall_q && pipe_we)
                err_q <= 1'b1;
        end
    end

    assign pipe_stall = stall_q;
    assign err        = err_q;
`else
    assign stall_q    = 1'b0;
    assign grant      = !pipe_we && !empty;
    assign pipe_stall = 1'b0;
    assign err        = 1'b0;
`endif

    assign bypass = lu_valid && !pipe_we && empty && !stall_q;
    assign enq    = lu_valid && lu_ready && !bypass;

    always_comb begin
        rf_we   = 1'b0;
        rf_rd   = '0;
        rf_data = '0;
        if (!reset) begin
            if (grant) begin
                rf_we   = 1'b1;
                rf_rd   = head.rd;
                rf_data = head.data;
            end else if (pipe_we) begin
                rf_we   = 1'b1;
                rf_rd   = pipe_rd;
                rf_data = pipe_data;
            end else if (bypass) begin
                rf_we   = 1'b1;
                rf_rd   = lu_rd;
                rf_data = lu_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ  <= '0;
            rptr <= '0;
            wptr <= '0;
        end else begin
            if (enq)
                wptr <= wptr + AW'(1);
            if (grant)
                rptr <= rptr + AW'(1);
            case ({enq, grant})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: pointers and occupancy define what is live.
    always_ff @(posedge clock) begin
        if (enq)
            mem[wptr] <= '{rd: lu_rd, data: lu_data};
    end
endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Directed bench for cpu_wb_arbiter; outputs sampled on the falling edge.
// Starvation-guard scenarios follow WB_ARB_STARVE_GUARD_EN like the design.
module tb_cpu_wb_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready, rf_we, pipe_stall, err;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    int nchk = 0;
    int nerr = 0;

    cpu_wb_arbiter dut (
        .clock(clock), .reset(reset),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .pipe_stall(pipe_stall), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
        pipe_we = we; pipe_rd = rd; pipe_data = d;
    endtask

    task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_valid = v; lu_rd = rd; lu_data = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        pipe(1'b0, 5'd0, 32'h0);
        lu(1'b0, 5'd0, 32'h0);
        #2;
        // reset state, with stimulus active to prove it is masked
        pipe(1'b1, 5'd4, 32'h44);
        lu(1'b1, 5'd6, 32'h66);
        smp();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_lu_ready", lu_ready, 0);
        chk("rst_stall", pipe_stall, 0);
        chk("rst_err", err, 0);
        nxt();
        pipe(1'b0, 5'd0, 32'h0);
        lu(1'b0, 5'd0, 32'h0);
        nxt();
        reset = 1'b0;
        #1;

        // pipe writeback passes straight through
        pipe(1'b1, 5'd3, 32'hAA);
        smp();
        chk("pipe_we", rf_we, 1);
        chk("pipe_rd", rf_rd, 3);
        chk("pipe_data", rf_data, 32'hAA);
        chk("pipe_lu_ready", lu_ready, 1);
        nxt();

        // bypass: lu result written same cycle, nothing buffered
        pipe(1'b0, 5'd0, 32'h0);
        lu(1'b1, 5'd7, 32'h55);
        smp();
        chk("byp_we", rf_we, 1);
        chk("byp_rd", rf_rd, 7);
        chk("byp_data", rf_data, 32'h55);
        nxt();
        lu(1'b0, 5'd0, 32'h0);
        smp();
        chk("byp_empty_we", rf_we, 0);
        chk("byp_empty_ready", lu_ready, 1);
        nxt();

        // starvation: rd=9 buffered behind a continuous pipe stream
        do_reset();
        pipe(1'b1, 5'd1, 32'h11);
        lu(1'b1, 5'd9, 32'h99);
        smp();
        chk("st_c0_rd", rf_rd, 1);
        nxt();
        lu(1'b0, 5'd0, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            smp();
            chk($sformatf("st_c%0d_rd", c), rf_rd, 1);
            chk($sformatf("st_c%0d_stall", c), pipe_stall, 0);
            nxt();
        end
`ifdef WB_ARB_STARVE_GUARD_EN
        smp();
        chk("st_c5_stall", pipe_stall, 1);
        chk("st_c5_rd", rf_rd, 9);
        chk("st_c5_data", rf_data, 32'h99);
        chk("st_c5_we", rf_we, 1);
        nxt();
        smp();
        chk("st_c6_stall", pipe_stall, 0);
        chk("st_c6_err", err, 1);
        chk("st_c6_rd", rf_rd, 1);
        nxt();
        pipe(1'b0, 5'd0, 32'h0);
        smp();
        chk("st_empty_we", rf_we, 0);
        chk("st_err_sticky", err, 1);
        nxt();
        do_reset();
        smp();
        chk("st_err_cleared", err, 0);
        nxt();
`else
        smp();
        chk("ng_c5_stall", pipe_stall, 0);
        chk("ng_c5_rd", rf_rd, 1);
        nxt();
        pipe(1'b0, 5'd0, 32'h0);
        smp();
        chk("ng_drain_rd", rf_rd, 9);
        chk("ng_drain_data", rf_data, 32'h99);
        nxt();
        smp();
        chk("ng_empty_we", rf_we, 0);
        chk("ng_err", err, 0);
        nxt();
`endif

        // full buffer: third result held, FIFO order on drain
        do_reset();
        pipe(1'b1, 5'd1, 32'h11);
        lu(1'b1, 5'd10, 32'hA0);
        smp();
        chk("full_c0_ready", lu_ready, 1);
        nxt();
        lu(1'b1, 5'd11, 32'hB0);
        smp();
        chk("full_c1_ready", lu_ready, 1);
        chk("full_c1_rd", rf_rd, 1);
        nxt();
        lu(1'b1, 5'd12, 32'hC0);
        smp();
        chk("full_c2_ready", lu_ready, 0);
        chk("full_c2_rd", rf_rd, 1);
        nxt();
        pipe(1'b0, 5'd0, 32'h0);
        smp();
        chk("full_c3_rd", rf_rd, 10);
        chk("full_c3_data", rf_data, 32'hA0);
        chk("full_c3_ready", lu_ready, 0);
        nxt();
        smp();
        chk("full_c4_rd", rf_rd, 11);
        chk("full_c4_data", rf_data, 32'hB0);
        chk("full_c4_ready", lu_ready, 1);
        nxt();
        lu(1'b0, 5'd0, 32'h0);
        smp();
        chk("full_c5_rd", rf_rd, 12);
        chk("full_c5_data", rf_data, 32'hC0);
        nxt();
        smp();
        chk("full_c6_we", rf_we, 0);
        chk("full_err", err, 0);
        nxt();

        // reset mid-operation discards two buffered entries
        pipe(1'b1, 5'd1, 32'h11);
        lu(1'b1, 5'd20, 32'h20);
        nxt();
        lu(1'b1, 5'd21, 32'h21);
        nxt();
        pipe(1'b0, 5'd0, 32'h0);
        lu(1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        smp();
        chk("mrst_we", rf_we, 0);
        chk("mrst_ready", lu_ready, 0);
        nxt();
        reset = 1'b0;
        smp();
        chk("mrst_post_we", rf_we, 0);
        chk("mrst_post_ready", lu_ready, 1);
        nxt();
        smp();
        chk("mrst_post2_we", rf_we, 0);
        chk("mrst_post2_stall", pipe_stall, 0);
        nxt();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/cpu_wb_arbiter.md
CPU_WB_ARBITER -- requirements
Module: CPU_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter REG_W, default 5, register index width.
REQ-003 The block SHALL have parameter DEPTH, default 2, long-latency result buffer entries (power of two, >=2).
REQ-004 The block SHALL have parameter STARVE_MAX, default 4, blocked cycles tolerated before a forced pipeline stall (>=1).
REQ-005 The block SHALL have the port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1, asynchronous, active-high reset.
REQ-007 The block SHALL have the ports pipe_we, input, 1; pipe_rd, input, REG_W; pipe_data, input, DATA_W: in-order pipeline writeback request, no backpressure.
REQ-008 The block SHALL have the ports lu_valid, input, 1; lu_rd, input, REG_W; lu_data, input, DATA_W; lu_ready, output, 1: long-latency unit result, valid/ready handshake.
REQ-009 The block SHALL have the ports rf_we, output, 1; rf_rd, output, REG_W; rf_data, output, DATA_W: bank register write port and forwarding-unit writeback stage view.
REQ-010 The block SHALL have the port pipe_stall, output, 1, one-cycle request for the pipeline to hold writeback.
REQ-011 The block SHALL have the port err, output, 1, sticky protocol-violation flag.

Function
REQ-012 The block SHALL drive the rf_* outputs combinationally in the same cycle using this priority: stall slot -> buffer head; else pipe_we -> pipe; else buffer non-empty -> buffer head; else bypass -> lu; else rf_we=0.
REQ-013 The block SHALL perform a bypass when lu_valid=1, pipe_we=0, the buffer is empty and pipe_stall=0; the result writes the register file in that cycle and is not enqueued.
REQ-014 The block SHALL drive lu_ready=1 iff the registered occupancy is below DEPTH and reset is deasserted.
REQ-015 The block SHALL NOT pass a result through when full; lu_valid with lu_ready=0 SHALL be held by the producer, and data/rd changes while the producer waits are a producer fault that is not checked.
REQ-016 The block SHALL enqueue when lu_valid & lu_ready and no bypass occurs; the entry SHALL become visible as head on the next cycle.
REQ-017 The block SHALL dequeue the head in the same cycle it is granted; a simultaneous enqueue and dequeue leaves occupancy unchanged.
REQ-018 The buffer SHALL be FIFO; read/write pointers wrap modulo DEPTH; occupancy is held in a counter of clog2(DEPTH)+1 bits.
REQ-019 "Blocked" SHALL mean the buffer is non-empty and the head is not granted; wait_cnt increments on each blocked cycle and clears on any head grant or when the buffer is empty.
REQ-020 On a blocked cycle with wait_cnt==STARVE_MAX-1, the block SHALL register pipe_stall=1 for exactly the next cycle and clear wait_cnt.
REQ-021 With pipe_stall=1 the buffer head SHALL win; pipe_we=1 in that cycle SHALL be dropped and SHALL set err; err clears only on reset.
REQ-022 The block SHALL NOT check write-after-write ordering between pipe and long-latency results to the same rd; the scoreboard upstream is responsible.

Reset
REQ-023 While reset=1 the block SHALL hold rf_we=0, rf_rd=0, rf_data=0, lu_ready=0, pipe_stall=0, err=0, with occupancy, pointers and wait_cnt at 0.
REQ-024 A reset asserted mid-operation SHALL discard all buffered entries without writing them; the block SHALL behave as empty on the first cycle after deassertion.

Configuration
REQ-025 When macro WB_ARB_STARVE_GUARD_EN is defined, the block SHALL include wait_cnt, the pipe_stall generation and the err logic per REQ-019..021.
REQ-026 When WB_ARB_STARVE_GUARD_EN is undefined, the block SHALL tie pipe_stall=0 and err=0, drain the buffer only in cycles with pipe_we=0, and include no wait_cnt.

Verification
REQ-027 The bench SHALL check: pipe_we=1 rd=3 data=0xAA with lu idle -> same cycle rf_we=1 rf_rd=3 rf_data=0xAA, lu_ready=1.
REQ-028 The bench SHALL check: pipe_we=0, empty buffer, lu_valid=1 rd=7 data=0x55 -> same cycle rf_rd=7 rf_data=0x55, occupancy stays 0.
REQ-029 The bench SHALL check: pipe_we=1 held, lu pushes rd=9 at cycle 0 then lu_valid=0 -> cycles 1-4 rf_rd=pipe_rd, pipe_stall=1 in cycle 5 with rf_rd=9, then occupancy 0.
REQ-030 The bench SHALL check: pipe_we=1 held, lu_valid=1 for 3 cycles -> lu_ready falls to 0 after the second accept, the third result is held, and FIFO order is preserved on drain.
REQ-031 The bench SHALL check: pipe_we=1 during a pipe_stall cycle -> the head is written and err=1 until reset.
REQ-032 The bench SHALL check: reset pulsed with 2 entries buffered -> no rf_we for those entries, and lu_ready=1 on the first cycle after deassertion.
